// File: rtl/simd_acc_array_if.sv
// Stream bundle for simd_acc_array: a beat input channel and a held-result output channel.
interface simd_acc_array_if #(
    parameter int LANES = 4,
    parameter int IN_W  = 8,
    parameter int ACC_W = 10
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_last;
    logic [LANES*IN_W-1:0]    data_in;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*ACC_W-1:0]   data_out;
    logic [LANES-1:0]         out_ovf;

    modport master (
        output in_valid, in_last, data_in, out_ready,
        input  in_ready, out_valid, data_out, out_ovf
    );

    modport slave (
        input  in_valid, in_last, data_in, out_ready,
        output in_ready, out_valid, data_out, out_ovf
    );
endinterface

// File: rtl/simd_acc_array.sv
// LANES-wide signed accumulator: sums a batch of beats per lane (wrap or saturate),
// then holds the result and per-lane overflow flags until the consumer accepts it.
//
// state | meaning
// ACC   | accepting beats, in_ready=1
// HOLD  | result presented, out_valid=1, waiting for out_ready
module simd_acc_array #(
    parameter int LANES = 4,
    parameter int IN_W  = 8,
    parameter int ACC_W = 10,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sat_en,
    input  logic [CNT_W-1:0] acc_len,
    simd_acc_array_if.slave  bus
);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic signed [ACC_W-1:0]  acc_q [LANES];
    logic [LANES-1:0]         ovf_q;
    logic [CNT_W-1:0]         beats_left;
    logic                     first_q;
    logic                     sat_q;

    logic                     accept;
    logic                     out_hs;
    logic                     last_beat;
    logic [CNT_W-1:0]         len_eff;
    logic [LANES*ACC_W-1:0]   acc_first;
    logic [LANES*ACC_W-1:0]   acc_next;
    logic [LANES-1:0]         lane_ovf;

    assign accept  = bus.in_valid && (state_q == ACC);
    assign out_hs  = bus.out_ready && (state_q == HOLD);
    assign len_eff = (acc_len == '0) ? CNT_W'(1) : acc_len;

    // Down-counter of beats still owed; terminal count (or in_last) closes the batch.
    assign last_beat = accept && (bus.in_last ||
                       (first_q ? (len_eff == CNT_W'(1)) : (beats_left == CNT_W'(1))));

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [IN_W-1:0] din;
        logic signed [ACC_W:0]  sum;

        assign din         = bus.data_in[i*IN_W +: IN_W];
        assign sum         = (ACC_W+1)'(acc_q[i]) + (ACC_W+1)'(din);
        assign lane_ovf[i] = sum[ACC_W] ^ sum[ACC_W-1];
        assign acc_first[i*ACC_W +: ACC_W] = ACC_W'(din);
        assign acc_next[i*ACC_W +: ACC_W]  = (lane_ovf[i] && sat_q) ?
                                             (sum[ACC_W] ? ACC_MIN : ACC_MAX) :
                                             sum[ACC_W-1:0];
        assign bus.data_out[i*ACC_W +: ACC_W] = acc_q[i];
    end

    assign bus.out_ovf = ovf_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            ACC: begin
                bus.in_ready = 1'b1;
                if (last_beat) state_d = HOLD;
            end
            HOLD: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = ACC;
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
            ovf_q      <= '0;
            beats_left <= '0;
            first_q    <= 1'b1;
            sat_q      <= 1'b0;
        end else if (out_hs) begin
            ovf_q      <= '0;
            beats_left <= '0;
            first_q    <= 1'b1;
        end else if (accept) begin
            first_q <= 1'b0;
            if (first_q) begin
                // Batch mode is frozen on the first beat; later sat_en/acc_len are ignored.
                sat_q      <= sat_en;
                beats_left <= len_eff - CNT_W'(1);
                for (int i = 0; i < LANES; i++) acc_q[i] <= acc_first[i*ACC_W +: ACC_W];
            end else begin
                beats_left <= beats_left - CNT_W'(1);
                ovf_q      <= ovf_q | lane_ovf;
                for (int i = 0; i < LANES; i++) acc_q[i] <= acc_next[i*ACC_W +: ACC_W];
            end
        end
    end
endmodule

// File: tb/tb_simd_acc_array.sv
// Randomized bench for simd_acc_array against an integer-arithmetic batch model.
module tb_simd_acc_array;
    logic       clk;
    logic       reset;
    logic       sat_en;
    logic [3:0] acc_len;

    simd_acc_array_if #(.LANES(4), .IN_W(8), .ACC_W(10)) bus ();

    simd_acc_array #(.LANES(4), .IN_W(8), .ACC_W(10), .CNT_W(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .sat_en  (sat_en),
        .acc_len (acc_len),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int bd [16][4];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_data(input int b);
        for (int l = 0; l < 4; l++) bus.data_in[l*8 +: 8] = bd[b][l][7:0];
    endtask

    task automatic rand_data(input int b);
        for (int l = 0; l < 4; l++) bd[b][l] = int'($urandom_range(0, 255)) - 128;
    endtask

    // len: acc_len on the first beat; last_idx: beat index carrying in_last (-1 none);
    // hold: cycles out_ready stays low after the result appears.
    task automatic run_batch(input int len, input bit sat, input int last_idx, input int hold);
        int leff, n, s, w;
        int acc [4];
        bit ovf [4];
        logic [39:0] exp_d;
        logic [3:0]  exp_o;
        leff = (len == 0) ? 1 : len;
        n = leff;
        if (last_idx >= 0 && last_idx + 1 < n) n = last_idx + 1;
        for (int l = 0; l < 4; l++) begin
            ovf[l] = 1'b0;
            acc[l] = bd[0][l];
            for (int b = 1; b < n; b++) begin
                s = acc[l] + bd[b][l];
                if (s > 511 || s < -512) begin
                    ovf[l] = 1'b1;
                    if (sat) acc[l] = (s > 511) ? 511 : -512;
                    else begin
                        w = s & 1023;
                        acc[l] = (w >= 512) ? w - 1024 : w;
                    end
                end else acc[l] = s;
            end
            exp_d[l*10 +: 10] = acc[l][9:0];
            exp_o[l] = ovf[l];
        end
        for (int b = 0; b < n; b++) begin
            chk("in_ready_acc", bus.in_ready, 1);
            chk("out_valid_acc", bus.out_valid, 0);
            bus.in_valid = 1'b1;
            bus.in_last  = (b == last_idx);
            sat_en  = (b == 0) ? sat : 1'($urandom_range(0, 1));
            acc_len = (b == 0) ? 4'(len) : 4'($urandom_range(0, 15));
            drive_data(b);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk("out_valid", bus.out_valid, 1);
        chk("data_out", bus.data_out, exp_d);
        chk("out_ovf", bus.out_ovf, exp_o);
        for (int k = 0; k < hold; k++) begin
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'b1;
            rand_data(15);
            drive_data(15);
            @(posedge clk); #1;
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_in_ready", bus.in_ready, 0);
            chk("hold_data", bus.data_out, exp_d);
            chk("hold_ovf", bus.out_ovf, exp_o);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("released", bus.out_valid, 0);
        chk("ovf_cleared", bus.out_ovf, 0);
    endtask

    initial begin
        reset         = 1'b0;
        sat_en        = 1'b0;
        acc_len       = 4'd0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.data_in   = '0;
        bus.out_ready = 1'b1;
        #2;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_data", bus.data_out, 0);
        chk("rst_ovf", bus.out_ovf, 0);
        #10 reset = 1'b1;
        @(posedge clk); #1;

        // Basic sum: lane0 10..40, lane1 -128 x4
        for (int b = 0; b < 4; b++) begin
            bd[b][0] = 10 * (b + 1); bd[b][1] = -128; bd[b][2] = 0; bd[b][3] = 0;
        end
        run_batch(4, 1'b0, -1, 0);

        // Saturation high on all lanes, then lane2 saturating low
        for (int b = 0; b < 5; b++) for (int l = 0; l < 4; l++) bd[b][l] = 127;
        run_batch(5, 1'b1, -1, 0);
        for (int b = 0; b < 5; b++) bd[b][2] = -128;
        run_batch(5, 1'b1, -1, 0);

        // Wrap on lane0, other lanes random
        for (int b = 0; b < 5; b++) begin
            rand_data(b);
            bd[b][0] = 127;
        end
        run_batch(5, 1'b0, -1, 0);

        // Backpressure for three cycles
        for (int b = 0; b < 3; b++) rand_data(b);
        run_batch(3, 1'b0, -1, 3);

        // Early end via in_last on beat 2, then a fresh batch
        for (int b = 0; b < 8; b++) rand_data(b);
        bd[0][0] = 5; bd[1][0] = 6;
        run_batch(8, 1'b0, 1, 0);
        for (int b = 0; b < 2; b++) rand_data(b);
        run_batch(2, 1'b1, -1, 0);

        // Single-beat batches: acc_len 0, acc_len 1, in_last on first beat
        rand_data(0); run_batch(0, 1'b0, -1, 0);
        rand_data(0); run_batch(1, 1'b1, -1, 0);
        rand_data(0); run_batch(5, 1'b0, 0, 1);

        for (int t = 0; t < 25; t++) begin
            for (int b = 0; b < 16; b++) rand_data(b);
            run_batch(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1,
                      int'($urandom_range(0, 2)));
        end

        // Reset mid-batch: two beats of 3, asynchronous reset between edges
        for (int b = 0; b < 2; b++) begin
            bus.in_valid = 1'b1;
            sat_en = 1'b0;
            acc_len = 4'd4;
            for (int l = 0; l < 4; l++) bus.data_in[l*8 +: 8] = 8'd3;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        chk("pre_reset_data", bus.data_out, {4{10'd6}});
        #1 reset = 1'b0;
        #1;
        chk("async_rst_data", bus.data_out, 0);
        chk("async_rst_ovf", bus.out_ovf, 0);
        chk("async_rst_valid", bus.out_valid, 0);
        chk("async_rst_ready", bus.in_ready, 1);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        for (int b = 0; b < 4; b++) for (int l = 0; l < 4; l++) bd[b][l] = 1;
        run_batch(4, 1'b0, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/simd_acc_array.md
SIMD_ACC_ARRAY -- requirements
Module: simd_acc_array

Interface
REQ-001 SHALL have parameter LANES, default 4: number of independent accumulator lanes.
REQ-002 SHALL have parameter IN_W, default 8: signed input element width.
REQ-003 SHALL have parameter ACC_W, default 10: signed accumulator width. ACC_W >= IN_W.
REQ-004 SHALL have parameter CNT_W, default 4: width of the beat counter and of acc_len.
REQ-005 SHALL have port clk, input, 1: single clock. All state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port sat_en, input, 1: 1 = saturating add, 0 = wrap-around add.
REQ-008 SHALL have port acc_len, input, CNT_W: beats per batch.
REQ-009 SHALL have port in_valid, input, 1: data_in beat offered.
REQ-010 SHALL have port in_ready, output, 1: block accepts a beat.
REQ-011 SHALL have port in_last, input, 1: the offered beat ends the batch early.
REQ-012 SHALL have port data_in, input, LANES*IN_W: signed elements; lane i occupies bits [i*IN_W +: IN_W].
REQ-013 SHALL have port out_valid, output, 1: batch result presented.
REQ-014 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-015 SHALL have port data_out, output, LANES*ACC_W: signed lane sums; lane i occupies bits [i*ACC_W +: ACC_W].
REQ-016 SHALL have port out_ovf, output, LANES: per-lane overflow flag for the presented batch.

Function
REQ-017 SHALL implement a two-state FSM. In ACC, in_ready=1 and out_valid=0. In HOLD, in_ready=0 and out_valid=1.
REQ-018 SHALL accept a beat only when in_valid && in_ready.
REQ-019 SHALL sample acc_len and sat_en on the first accepted beat of a batch and hold them for the whole batch. acc_len=0 SHALL be treated as 1.
REQ-020 On the first beat of a batch, each lane SHALL load sext(data_in lane). On every later beat, each lane SHALL load acc + sext(data_in lane).
REQ-021 Overflow SHALL mean the exact sum lies outside [-2^(ACC_W-1), 2^(ACC_W-1)-1].
- With sat_en=1, the lane clamps to the violated bound.
- With sat_en=0, the lane keeps the low ACC_W bits.
REQ-022 On overflow, the lane's out_ovf bit SHALL set and stay set until the batch is accepted.
REQ-023 SHALL count accepted beats. The beat that makes the count equal the latched length, or any accepted beat with in_last=1, SHALL move the FSM ACC->HOLD.
REQ-024 Latency: out_valid SHALL rise in the cycle after the final beat is accepted, with data_out and out_ovf already including that beat.
REQ-025 In HOLD, data_out and out_ovf SHALL remain stable until out_valid && out_ready.
REQ-026 On out_valid && out_ready, the FSM SHALL return to ACC, clear the counter and out_ovf, and mark the next accepted beat as first.
REQ-027 in_valid during HOLD SHALL have no effect. No bubble-free overlap is required: a new batch starts no earlier than the cycle after the handshake.
REQ-028 Lanes SHALL be independent. Overflow or saturation in one lane SHALL NOT affect another.
REQ-029 A single-beat batch (acc_len=1, or in_last on the first beat) SHALL produce data_out = sext(data_in), with out_ovf=0.

Reset
REQ-030 With reset=0, the following SHALL be cleared immediately, independent of clk: FSM=ACC, counter=0, all accumulators=0, out_ovf=0, out_valid=0, first-beat flag=1.
REQ-031 Reset asserted mid-batch or in HOLD SHALL discard all partial results. The first accepted beat after deassertion starts a new batch.

Verification
Bench parameters: LANES=4, IN_W=8, ACC_W=10, CNT_W=4.
REQ-032 Basic sum: acc_len=4, lane0 = 10,20,30,40, lane1 = -128 x4, all beats back-to-back, out_ready=1 -> one cycle after beat 4: out_valid=1, lane0=100, lane1=-512, out_ovf=0.
REQ-033 Saturation: sat_en=1, acc_len=5, all lanes 127 -> lanes=511, out_ovf=4'b1111. Same stimulus with lane 2 = -128 x5 -> lane2=-512, out_ovf[2]=1.
REQ-034 Wrap: sat_en=0, acc_len=5, lane0=127 x5 -> lane0=-389 (635-1024), out_ovf[0]=1.
REQ-035 Backpressure: out_ready=0 for 3 cycles after out_valid with in_valid held 1 -> data_out unchanged, in_ready=0, no beats consumed. out_ready=1 -> next batch's first beat accepted the following cycle.
REQ-036 Early end: acc_len=8, in_last on beat 2, lane0 = 5,6 -> lane0=11 one cycle later. Next batch starts fresh.
REQ-037 Reset mid-batch: after 2 of 4 beats, pulse reset low between clock edges -> outputs 0 immediately. A following 4-beat batch of 1s -> lanes=4.
